// File: rtl/jt900h_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jt900h_pkg
// Description : Shared definitions for the JT900H memory access unit.
//               Provides the access size encodings, the access FSM state
//               constants and a helper that gives the byte count of a size.
// Revision    : 1.0  initial release
// ============================================================================
package jt900h_pkg;

  // Access size encodings. Encoding 3 is handled as a long access.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_WORD = 2'd1;
  localparam logic [1:0] SZ_LONG = 2'd2;

  // Memory access FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CYC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Number of bytes moved by an access of the given size
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_WORD: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/jt900h_memacc_lanes.sv
`default_nettype none
// ============================================================================
// Module      : jt900h_memacc_lanes
// Description : Combinational byte-lane calculator for one 16-bit bus cycle
//               of a byte/word/long access.
// Ports       : i_a0    - bit 0 of the access start byte address
//               i_size  - access size (SZ_BYTE / SZ_WORD / SZ_LONG, 3 = long)
//               i_idx   - index of the current bus cycle within the access
//               o_dsn   - active-low lane enables ([0] even, [1] odd lane)
//               o_off0  - byte offset in the access carried by lane 0
//               o_off1  - byte offset in the access carried by lane 1
//               o_last  - current cycle is the final one of the access
// Revision    : 1.0  initial release
// ============================================================================
module jt900h_memacc_lanes
  import jt900h_pkg::*;
(
  input  logic       i_a0,
  input  logic [1:0] i_size,
  input  logic [1:0] i_idx,
  output logic [1:0] o_dsn,
  output logic [1:0] o_off0,
  output logic [1:0] o_off1,
  output logic       o_last
);

  logic [3:0] w_nbytes;
  logic [3:0] w_pos0;
  logic [3:0] w_rel0;
  logic [3:0] w_rel1;
  logic [3:0] w_ncyc;

  assign w_nbytes = {1'b0, size_bytes(i_size)};

  // Even-lane byte position relative to the word-aligned start of the access
  assign w_pos0 = {1'b0, i_idx, 1'b0};

  // Offset of each lane relative to the first byte of the access. The byte
  // before an odd start address wraps to 4'hF, which is never < byte count,
  // so that lane is disabled without a special case.
  assign w_rel0 = w_pos0 - {3'b000, i_a0};
  assign w_rel1 = w_pos0 + 4'd1 - {3'b000, i_a0};

  // ceil((a0 + bytes) / 2) bus cycles per access
  assign w_ncyc = ({3'b000, i_a0} + w_nbytes + 4'd1) >> 1;

  assign o_last = (({2'b00, i_idx} + 4'd1) == w_ncyc);
  assign o_dsn  = {~(w_rel1 < w_nbytes), ~(w_rel0 < w_nbytes)};
  assign o_off0 = w_rel0[1:0];
  assign o_off1 = w_rel1[1:0];

endmodule
`default_nettype wire

// File: rtl/jt900h_memacc.sv
`default_nettype none
// ============================================================================
// Module      : jt900h_memacc
// Description : Byte/word/long memory access sequencer for a 16-bit bus.
//               Splits an access into one to three bus cycles, steering the
//               little-endian data onto the proper byte lanes.
// Ports       : rst, clk                 - async active-high reset, clock
//               start, addr, size, we,   - request strobe and its attributes
//               wdata
//               busy, done, rdata, err   - status, completion pulse, result
//               bus_addr, bus_cs, bus_we,- 16-bit bus master side
//               bus_dsn, bus_dout,
//               bus_din, bus_ok
// Config      : JT900H_MEMACC_TOUT_EN - when defined, a bus cycle that waits
//               TOUT cycles for bus_ok is aborted with err=1.
// Revision    : 1.0  initial release
// ============================================================================
module jt900h_memacc
  import jt900h_pkg::*;
#(
  parameter logic [7:0] TOUT = 8'd255
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [1:0]  size,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [22:0] bus_addr,
  output logic        bus_cs,
  output logic        bus_we,
  output logic [1:0]  bus_dsn,
  output logic [15:0] bus_dout,
  input  logic [15:0] bus_din,
  input  logic        bus_ok
);

  logic [1:0]  r_state;
  logic [22:0] r_addr;
  logic        r_a0;
  logic [1:0]  r_size;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [1:0]  r_idx;
  logic [31:0] r_rdata;

  logic [1:0]  w_dsn;
  logic [1:0]  w_off0;
  logic [1:0]  w_off1;
  logic        w_last;
  logic        w_cyc;
  logic [7:0]  w_wb0;
  logic [7:0]  w_wb1;

  jt900h_memacc_lanes u_lanes (
    .i_a0   (r_a0),
    .i_size (r_size),
    .i_idx  (r_idx),
    .o_dsn  (w_dsn),
    .o_off0 (w_off0),
    .o_off1 (w_off1),
    .o_last (w_last)
  );

  assign w_cyc = (r_state == ST_CYC);
  assign w_wb0 = r_wdata[{w_off0, 3'b000} +: 8];
  assign w_wb1 = r_wdata[{w_off1, 3'b000} +: 8];

`ifdef JT900H_MEMACC_TOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;

  assign err = done & r_err;
`else
  logic [7:0] w_unused_tout;

  assign w_unused_tout = TOUT;
  assign err           = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= 23'd0;
      r_a0    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_we    <= 1'b0;
      r_wdata <= 32'd0;
      r_idx   <= 2'd0;
      r_rdata <= 32'd0;
`ifdef JT900H_MEMACC_TOUT_EN
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr  <= addr[23:1];
            r_a0    <= addr[0];
            r_size  <= size;
            r_we    <= we;
            r_wdata <= wdata;
            r_idx   <= 2'd0;
            r_rdata <= 32'd0;
            r_state <= ST_CYC;
`ifdef JT900H_MEMACC_TOUT_EN
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
`endif
          end
        end
        ST_CYC: begin
          if (bus_ok) begin
            if (!r_we) begin
              if (!w_dsn[0]) r_rdata[{w_off0, 3'b000} +: 8] <= bus_din[7:0];
              if (!w_dsn[1]) r_rdata[{w_off1, 3'b000} +: 8] <= bus_din[15:8];
            end
            if (w_last) begin
              r_state <= ST_DONE;
            end else begin
              // 23-bit word address rolls over naturally at the top of memory
              r_idx  <= r_idx + 2'd1;
              r_addr <= r_addr + 23'd1;
`ifdef JT900H_MEMACC_TOUT_EN
              r_cnt  <= 8'd0;
`endif
            end
          end
`ifdef JT900H_MEMACC_TOUT_EN
          else if (r_cnt == TOUT - 8'd1) begin
            r_state <= ST_DONE;
            r_err   <= 1'b1;
            r_rdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign rdata    = r_rdata;
  assign bus_addr = r_addr;
  assign bus_cs   = w_cyc;
  assign bus_we   = w_cyc & r_we;
  assign bus_dsn  = w_cyc ? w_dsn : 2'b11;
  assign bus_dout = (w_cyc && r_we) ?
                    {(w_dsn[1] ? 8'h00 : w_wb1), (w_dsn[0] ? 8'h00 : w_wb0)} :
                    16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_jt900h_memacc.sv
`default_nettype none
// ============================================================================
// Module      : tb_jt900h_memacc
// Description : Self-checking bench for jt900h_memacc. The bus side is a
//               randomly stalling memory whose contents are a fixed function
//               of the word address; expectations come from byte-level
//               arithmetic on the access address and size.
// Revision    : 1.0  initial release
// ============================================================================
module tb_jt900h_memacc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] addr;
  logic [1:0]  size;
  logic        we;
  logic [31:0] wdata;
  logic        busy, done, err, bus_cs, bus_we, bus_ok;
  logic [31:0] rdata;
  logic [22:0] bus_addr;
  logic [1:0]  bus_dsn;
  logic [15:0] bus_dout, bus_din;

  jt900h_memacc #(.TOUT(8'd8)) dut (
    .rst(rst), .clk(clk), .start(start), .addr(addr), .size(size), .we(we),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
    .bus_addr(bus_addr), .bus_cs(bus_cs), .bus_we(bus_we), .bus_dsn(bus_dsn),
    .bus_dout(bus_dout), .bus_din(bus_din), .bus_ok(bus_ok)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder configuration
  int          wait_pct = 0;
  bit          noise    = 0;
  logic [15:0] din_q[$];

  // Observations of the last access
  logic [22:0] log_addr[$];
  logic [1:0]  log_dsn[$];
  logic [15:0] log_dout[$];
  logic        log_we[$];
  int          acc_cycles;
  logic [31:0] acc_rdata;
  logic        acc_err;
  bit          acc_done;
  bit          acc_timeout;
  bit          acc_unstable;
  bit          acc_after_bad;

  function automatic logic [15:0] mem_word(input logic [22:0] wa);
    return {wa[7:0] ^ 8'hC3, wa[15:8] + wa[7:0] + {1'b0, wa[22:16]}};
  endfunction

  function automatic logic [7:0] mem_byte(input logic [23:0] ba);
    logic [15:0] w;
    w = mem_word(ba[23:1]);
    return ba[0] ? w[15:8] : w[7:0];
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  // Issue one request and play the bus slave until the cycle after done
  task automatic do_access(input logic [23:0] a, input logic [1:0] sz,
                           input logic w, input logic [31:0] d);
    logic [22:0] h_addr;
    logic [1:0]  h_dsn;
    logic [15:0] h_dout;
    bit          h_pend;
    int          guard;
    log_addr.delete(); log_dsn.delete(); log_dout.delete(); log_we.delete();
    acc_cycles = 0; acc_rdata = '0; acc_err = 1'b0; acc_done = 0;
    acc_timeout = 0; acc_unstable = 0; acc_after_bad = 0;
    h_pend = 0; guard = 0;
    h_addr = '0; h_dsn = '0; h_dout = '0;
    @(negedge clk);
    addr = a; size = sz; we = w; wdata = d; start = 1'b1;
    forever begin
      @(negedge clk);
      start = 1'b0; bus_ok = 1'b0; bus_din = 16'($urandom);
      if (acc_done) begin
        acc_after_bad = busy || done || bus_cs;
        break;
      end
      if (noise && busy) begin
        start = 1'($urandom_range(0, 1));
        addr = 24'($urandom); size = 2'($urandom); we = 1'($urandom);
        wdata = $urandom;
      end
      if (done) begin
        acc_done = 1; acc_rdata = rdata; acc_err = err;
        if (noise) start = 1'b1;
      end
      if (bus_cs) begin
        if (h_pend && (bus_addr !== h_addr || bus_dsn !== h_dsn || bus_dout !== h_dout))
          acc_unstable = 1;
        if (int'($urandom_range(0, 99)) >= wait_pct) begin
          bus_ok = 1'b1;
          if (din_q.size() > 0) bus_din = din_q.pop_front();
          else bus_din = mem_word(bus_addr);
          log_addr.push_back(bus_addr); log_dsn.push_back(bus_dsn);
          log_dout.push_back(bus_dout); log_we.push_back(bus_we);
          acc_cycles++; h_pend = 0;
        end else begin
          h_pend = 1; h_addr = bus_addr; h_dsn = bus_dsn; h_dout = bus_dout;
        end
      end
      guard++;
      if (guard > 400) begin acc_timeout = 1; break; end
    end
    start = 1'b0; bus_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bus_ok = 1'b0; bus_din = 16'h0;
    addr = '0; size = '0; we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, bus_cs, bus_we} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {busy, done, err, bus_cs, bus_we});
    end
    checks++;
    if (bus_dsn !== 2'b11) begin
      errors++; $display("FAIL reset_dsn: got %b want 11", bus_dsn);
    end
    checks++;
    if ({rdata, bus_addr, bus_dout} !== 71'd0) begin
      errors++; $display("FAIL reset_data: rdata %h bus_addr %h bus_dout %h want 0", rdata, bus_addr, bus_dout);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_byte_read();
    wait_pct = 0; noise = 0; din_q = {16'hAB00};
    do_access(24'h001235, 2'd0, 1'b0, 32'h0);
    checks++;
    if (acc_cycles !== 1 || acc_timeout) begin
      errors++; $display("FAIL byte_read_cycles: got %0d want 1", acc_cycles);
    end
    checks++;
    if (log_addr.size() < 1 || log_addr[0] !== 23'h00091A || log_dsn[0] !== 2'b01) begin
      errors++; $display("FAIL byte_read_bus: addr %h dsn %b want 00091a 01",
                         (log_addr.size() > 0) ? log_addr[0] : 23'h0, (log_dsn.size() > 0) ? log_dsn[0] : 2'b0);
    end
    checks++;
    if (acc_rdata !== 32'h000000AB || !acc_done) begin
      errors++; $display("FAIL byte_read_data: got %h done %0d want 000000ab", acc_rdata, acc_done);
    end
  endtask

  task automatic test_long_read();
    wait_pct = 0; noise = 0; din_q = {16'h5678, 16'h1234};
    do_access(24'h001000, 2'd2, 1'b0, 32'h0);
    checks++;
    if (acc_cycles !== 2) begin
      errors++; $display("FAIL long_read_cycles: got %0d want 2", acc_cycles);
    end
    checks++;
    if (acc_rdata !== 32'h12345678 || !acc_done) begin
      errors++; $display("FAIL long_read_data: got %h want 12345678", acc_rdata);
    end
    checks++;
    if (acc_after_bad) begin
      errors++; $display("FAIL long_read_done_pulse: done/busy not cleared after one cycle");
    end
  endtask

  task automatic test_word_write();
    wait_pct = 0; noise = 0; din_q.delete();
    do_access(24'h000101, 2'd1, 1'b1, 32'h0000BEEF);
    checks++;
    if (acc_cycles !== 2) begin
      errors++; $display("FAIL word_write_cycles: got %0d want 2", acc_cycles);
    end
    if (acc_cycles == 2) begin
      checks++;
      if (log_dsn[0] !== 2'b01 || log_dout[0] !== 16'hEF00) begin
        errors++; $display("FAIL word_write_c1: dsn %b dout %h want 01 ef00", log_dsn[0], log_dout[0]);
      end
      checks++;
      if (log_dsn[1] !== 2'b10 || log_dout[1] !== 16'h00BE || log_we[1] !== 1'b1) begin
        errors++; $display("FAIL word_write_c2: dsn %b dout %h we %b want 10 00be 1", log_dsn[1], log_dout[1], log_we[1]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    wait_pct = 0; noise = 0; din_q.delete();
    exp = {mem_byte(24'h000002), mem_byte(24'h000001), mem_byte(24'h000000), mem_byte(24'hFFFFFF)};
    do_access(24'hFFFFFF, 2'd2, 1'b0, 32'h0);
    checks++;
    if (acc_cycles !== 3) begin
      errors++; $display("FAIL wrap_cycles: got %0d want 3", acc_cycles);
    end
    if (acc_cycles == 3) begin
      checks++;
      if (log_addr[0] !== 23'h7FFFFF || log_addr[1] !== 23'h000000 || log_addr[2] !== 23'h000001) begin
        errors++; $display("FAIL wrap_addr: got %h %h %h want 7fffff 000000 000001", log_addr[0], log_addr[1], log_addr[2]);
      end
    end
    checks++;
    if (acc_rdata !== exp) begin
      errors++; $display("FAIL wrap_data: got %h want %h", acc_rdata, exp);
    end
  endtask

  task automatic test_timeout();
    int waits;
    bit got;
    bit busy_drop;
    waits = 0; got = 0; busy_drop = 0;
    @(negedge clk);
    addr = 24'h000400; size = 2'd0; we = 1'b0; wdata = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bus_ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin got = 1; break; end
      if (!busy) busy_drop = 1;
      if (bus_cs) waits++;
      @(negedge clk);
    end
`ifdef JT900H_MEMACC_TOUT_EN
    checks++;
    if (!got || waits !== 8) begin
      errors++; $display("FAIL timeout_waits: done %0d waits %0d want 1 8", got, waits);
    end
    checks++;
    if (err !== 1'b1 || rdata !== 32'h0) begin
      errors++; $display("FAIL timeout_err: err %b rdata %h want 1 0", err, rdata);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL timeout_release: busy %b err %b want 0 0", busy, err);
    end
`else
    checks++;
    if (got || busy_drop || err !== 1'b0) begin
      errors++; $display("FAIL no_timeout_hold: done %0d busy_drop %0d err %b want 0 0 0", got, busy_drop, err);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    bit bad;
    logic [31:0] exp;
    bad = 0;
    @(negedge clk);
    addr = 24'h002000; size = 2'd2; we = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bus_ok = 1'b1; bus_din = 16'h1111;
    @(negedge clk);
    bus_ok = 1'b0;
    checks++;
    if (bus_cs !== 1'b1 || bus_addr !== 23'h001001) begin
      errors++; $display("FAIL rst_mid_second: cs %b addr %h want 1 001001", bus_cs, bus_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus_cs !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: cs %b busy %b done %b want 0 0 0", bus_cs, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done || bus_cs || busy) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL rst_mid_quiet: activity after reset without start");
    end
    wait_pct = 20; noise = 0; din_q.delete();
    exp = {mem_byte(24'h002003), mem_byte(24'h002002), mem_byte(24'h002001), mem_byte(24'h002000)};
    do_access(24'h002000, 2'd2, 1'b0, 32'h0);
    checks++;
    if (acc_rdata !== exp || acc_cycles !== 2 || !acc_done) begin
      errors++; $display("FAIL rst_mid_next: rdata %h cycles %0d want %h 2", acc_rdata, acc_cycles, exp);
    end
  endtask

  task automatic test_random();
    logic [23:0] a, ba, off;
    logic [1:0]  sz, edsn;
    logic        w;
    logic [31:0] d, exp;
    logic [15:0] edout;
    int          n, ecyc;
    bit          busbad;
    logic [23:0] corner[4];
    corner[0] = 24'hFFFFFF; corner[1] = 24'hFFFFFE; corner[2] = 24'h000000; corner[3] = 24'h000001;
    noise = 1; din_q.delete();
    for (int t = 0; t < 40; t++) begin
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 24'($urandom);
      sz = 2'($urandom);
      w  = 1'($urandom);
      d  = $urandom;
      wait_pct = $urandom_range(0, 60);
      n = nbytes(sz);
      ecyc = (int'(a[0]) + n + 1) / 2;
      exp = '0;
      if (!w)
        for (int i = 0; i < n; i++) begin
          ba = a + 24'(i);
          exp[8*i +: 8] = mem_byte(ba);
        end
      do_access(a, sz, w, d);
      checks++;
      if (acc_timeout || !acc_done || acc_cycles !== ecyc) begin
        errors++; $display("FAIL rnd_cycles[%0d]: addr %h size %0d cycles %0d done %0d want %0d", t, a, sz, acc_cycles, acc_done, ecyc);
      end
      checks++;
      if (acc_rdata !== exp || acc_err !== 1'b0) begin
        errors++; $display("FAIL rnd_rdata[%0d]: addr %h size %0d we %0d got %h err %b want %h", t, a, sz, w, acc_rdata, acc_err, exp);
      end
      checks++;
      if (acc_after_bad || acc_unstable) begin
        errors++; $display("FAIL rnd_handshake[%0d]: after_done %0d unstable %0d want 0 0", t, acc_after_bad, acc_unstable);
      end
      busbad = 0;
      for (int k = 0; k < log_addr.size(); k++) begin
        if (log_addr[k] !== a[23:1] + 23'(k) || log_we[k] !== w) busbad = 1;
        edsn = 2'b11; edout = 16'h0;
        for (int l = 0; l < 2; l++) begin
          ba  = {log_addr[k], 1'(l)};
          off = ba - a;
          if (off < 24'(n)) begin
            edsn[l] = 1'b0;
            if (w) edout[8*l +: 8] = d[8*off[1:0] +: 8];
          end
        end
        if (log_dsn[k] !== edsn || (w && log_dout[k] !== edout) || (!w && log_dout[k] !== 16'h0))
          busbad = 1;
      end
      checks++;
      if (busbad) begin
        errors++; $display("FAIL rnd_bus[%0d]: addr %h size %0d we %0d lane/address sequence wrong", t, a, sz, w);
      end
    end
    noise = 0;
  endtask

  initial begin
    test_reset();
    test_byte_read();
    test_long_read();
    test_word_write();
    test_wrap();
    test_timeout();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
